// File: rtl/insert_sort_pkg.sv
// Purpose: shared types and width helpers for the insert sort / unsort pair.
// Latency: not applicable (declarations only).
// Backpressure: not applicable.
package insert_sort_pkg;

    // Two legal controller states; any other encoding is treated as corruption.
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SCATTER = 2'd1
    } state_t;

    // Position and index width: one extra bit so that n itself is representable.
    function automatic int pos_width(input int n);
        return $clog2(n) + 1;
    endfunction

endpackage

// File: rtl/unsort_seen_tracker.sv
// Purpose: bitmap of written slots; flags out-of-range or repeated positions.
// Latency: perm_error_o rises the cycle after the offending write.
// Backpressure: none; one position may be checked every cycle.
module unsort_seen_tracker
    import insert_sort_pkg::*;
#(
    parameter int INPUTVALS = 16,
    parameter int PW        = 5
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          clear_i,
    input  logic          wr_en_i,
    input  logic [PW-1:0] pos_i,
    output logic          perm_error_o
);

    localparam int            IW    = (INPUTVALS > 1) ? $clog2(INPUTVALS) : 1;
    localparam logic [PW-1:0] NVALS = PW'(INPUTVALS);

    logic [INPUTVALS-1:0] seen_q;
    logic                 err_q;

    // Mark each written slot; a range miss or second hit makes the flag sticky.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            seen_q <= '0;
            err_q  <= 1'b0;
        end else if (clear_i) begin
            seen_q <= '0;
            err_q  <= 1'b0;
        end else if (wr_en_i) begin
            if (pos_i >= NVALS) begin
                err_q <= 1'b1;
            end else begin
                if (seen_q[pos_i[IW-1:0]]) begin
                    err_q <= 1'b1;
                end
                seen_q[pos_i[IW-1:0]] <= 1'b1;
            end
        end
    end

    assign perm_error_o = err_q;

endmodule

// File: rtl/insert_unsort.sv
// Purpose: scatter sorted values back to their original slots using captured positions.
// Latency: INPUTVALS cycles from accepted start to unsortdone; next start accepted in the done cycle.
// Backpressure: none; unsortstart is ignored while busy. Optional checker: INSERT_UNSORT_CHECK_EN.
module insert_unsort
    import insert_sort_pkg::*;
#(
    parameter int INPUTVALS      = 16,
    parameter int INPUTBITWIDTHS = 32
) (
    input  logic                                          clk,
    input  logic                                          reset,
    input  logic                                          unsortstart,
    input  logic [INPUTVALS-1:0][INPUTBITWIDTHS-1:0]      sorted_in,
    input  logic [INPUTVALS-1:0][$clog2(INPUTVALS):0]     positions_in,
    output logic                                          busy,
    output logic                                          unsortdone,
    output logic [INPUTVALS-1:0][INPUTBITWIDTHS-1:0]      restored,
    output logic                                          perm_error,
    output logic                                          error
);

    localparam int            PW       = pos_width(INPUTVALS);
    localparam int            IW       = (INPUTVALS > 1) ? $clog2(INPUTVALS) : 1;
    localparam logic [PW-1:0] NVALS    = PW'(INPUTVALS);
    localparam logic [PW-1:0] LAST_IDX = PW'(INPUTVALS - 1);

    state_t                                     state_q, state_d;
    logic [INPUTVALS-1:0][INPUTBITWIDTHS-1:0]   values_q;
    logic [INPUTVALS-1:0][INPUTBITWIDTHS-1:0]   restored_q;
    logic [INPUTVALS-1:0][PW-1:0]               positions_q;
    logic [PW-1:0]                              index_q;
    logic                                       done_q;
    logic                                       error_q;

    logic                                       start_acc;
    logic                                       wr_en;
    logic [PW-1:0]                              cur_pos;
    logic [INPUTBITWIDTHS-1:0]                  cur_val;
    logic                                       pos_in_range;

    assign start_acc    = (state_q == IDLE) && unsortstart;
    assign wr_en        = (state_q == SCATTER);
    assign cur_pos      = positions_q[index_q[IW-1:0]];
    assign cur_val      = values_q[index_q[IW-1:0]];
    assign pos_in_range = (cur_pos < NVALS);

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state: start launches a scatter that ends after the last entry.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (unsortstart) state_d = SCATTER;
            SCATTER: if (index_q == LAST_IDX) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Outputs are direct views of registered state.
    always_comb begin
        busy       = (state_q != IDLE);
        unsortdone = done_q;
        error      = error_q;
        restored   = restored_q;
    end

    // Datapath: capture on start, one scatter write per cycle, recover on bad state.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            values_q    <= '0;
            positions_q <= '0;
            restored_q  <= '0;
            index_q     <= '0;
            done_q      <= 1'b0;
            error_q     <= 1'b0;
        end else begin
            done_q  <= 1'b0;
            error_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (unsortstart) begin
                        values_q    <= sorted_in;
                        positions_q <= positions_in;
                        restored_q  <= '0;
                        index_q     <= '0;
                    end
                end
                SCATTER: begin
                    // Out-of-range positions are dropped rather than aliased.
                    if (pos_in_range) begin
                        restored_q[cur_pos[IW-1:0]] <= cur_val;
                    end
                    index_q <= index_q + 1'b1;
                    if (index_q == LAST_IDX) begin
                        done_q <= 1'b1;
                    end
                end
                default: begin
                    restored_q <= '0;
                    error_q    <= 1'b1;
                end
            endcase
        end
    end

`ifdef INSERT_UNSORT_CHECK_EN
    unsort_seen_tracker #(
        .INPUTVALS (INPUTVALS),
        .PW        (PW)
    ) u_seen (
        .clk          (clk),
        .reset        (reset),
        .clear_i      (start_acc),
        .wr_en_i      (wr_en),
        .pos_i        (cur_pos),
        .perm_error_o (perm_error)
    );
`else
    // Without the checker duplicates resolve last-writer-wins and no flag is kept.
    assign perm_error = 1'b0;
`endif

endmodule

// File: doc/insert_unsort.md
INSERT_UNSORT -- requirements
Module: insert_unsort

Interface
REQ-001 SHALL have parameter INPUTVALS, default 16, number of list entries.
REQ-002 SHALL have parameter INPUTBITWIDTHS, default 32, bit width of each value.
REQ-003 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-004 SHALL have port reset, input, 1, asynchronous, active-high reset.
REQ-005 SHALL have port unsortstart, input, 1, request to begin restoring original order.
REQ-006 SHALL have port sorted_in, input, [INPUTVALS-1:0][INPUTBITWIDTHS-1:0], values in ascending order.
REQ-007 SHALL have port positions_in, input, [INPUTVALS-1:0][$clog2(INPUTVALS):0], original index of each sorted_in entry.
REQ-008 SHALL have port busy, output, 1, high while not in IDLE.
REQ-009 SHALL have port unsortdone, output, 1, one-cycle pulse when restored is complete.
REQ-010 SHALL have port restored, output, [INPUTVALS-1:0][INPUTBITWIDTHS-1:0], values in original input order.
REQ-011 SHALL have port perm_error, output, 1, sticky flag for an invalid position list.
REQ-012 SHALL have port error, output, 1, one-cycle pulse on illegal FSM state.

Function
REQ-013 SHALL implement FSM states IDLE and SCATTER; any other encoding pulses error, clears restored, returns to IDLE.
REQ-014 IDLE: on unsortstart=1, SHALL capture sorted_in and positions_in into internal registers, clear restored and perm_error, set index to 0, go to SCATTER.
REQ-015 unsortstart SHALL be ignored outside IDLE; input changes after capture SHALL have no effect.
REQ-016 SCATTER: each cycle SHALL write restored[positions[index]] <= values[index] and increment index; one entry per cycle.
REQ-017 SHALL treat position >= INPUTVALS as out of range: write skipped, never out-of-bounds indexing.
REQ-018 On the edge performing write index=INPUTVALS-1, SHALL set unsortdone=1 for one cycle and go to IDLE.
REQ-019 Latency: start sampled at edge T0 -> unsortdone high after edge T(INPUTVALS); restored valid from then until next accepted start.
REQ-020 unsortstart high during the unsortdone cycle SHALL be accepted (back-to-back period INPUTVALS+1 cycles).
REQ-021 index SHALL be $clog2(INPUTVALS)+1 bits wide so INPUTVALS is representable without wrap.

Reset
REQ-022 reset=1 SHALL immediately force IDLE; busy, unsortdone, perm_error, error = 0; restored and internal registers = 0.
REQ-023 reset mid-SCATTER SHALL abort: no unsortdone pulse, partial results cleared; next start behaves normally.

Configuration
REQ-024 Macro INSERT_UNSORT_CHECK_EN defined: SHALL keep a seen bitmap, set perm_error on any out-of-range or duplicate position, hold it until next accepted start.
REQ-025 Macro undefined: perm_error SHALL be tied 0, no bitmap logic; duplicate positions last-writer-wins, out-of-range writes skipped.

Structure
REQ-026 Shared package insert_sort_pkg SHALL hold the FSM state enum type and position-width constant helper, shared with the sorter.
REQ-027 Sub-module unsort_seen_tracker (bitmap + duplicate/range check) SHALL exist, instantiated only under INSERT_UNSORT_CHECK_EN.

Verification (INPUTVALS=4, INPUTBITWIDTHS=8)
REQ-028 sorted_in={3,5,9,12}, positions_in={2,0,3,1} -> restored={5,12,3,9}, unsortdone 4 cycles after start edge, perm_error=0.
REQ-029 positions_in={0,1,2,3} -> restored equals sorted_in; busy high exactly 4 cycles.
REQ-030 positions_in={1,1,2,3}, sorted_in={3,5,9,12} -> restored={0,5,9,12}; perm_error=1 with macro, 0 without.
REQ-031 positions_in={4,0,1,2} -> value 3 dropped, restored={5,9,12,0}; perm_error=1 with macro.
REQ-032 reset pulsed after 2 SCATTER writes -> all outputs 0, no unsortdone; fresh start then completes per REQ-028.
REQ-033 unsortstart held high continuously -> unsortdone every 5 cycles; start pulsed while busy -> ignored.
